conv_enc_framer: RTL and testbench

CONV_ENC_FRAMER -- requirements
Module: conv_enc_framer

---
 rtl/conv_enc_framer.sv | 132 +++++++++++++
 tb/tb_conv_enc_framer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_framer.sv
// K=3 rate-1/2 convolutional encoder (generators 7,5 octal) that frames FRAME_LEN data bits
// plus two flushing tail symbols, with a single ready/valid output register.
module conv_enc_framer #(
   parameter int unsigned FRAME_LEN = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        encoder_i,
   input  logic        enable_encoder_i,
   output logic        encoder_ready_o,
   output logic [1:0]  encoder_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        sof_o,
   output logic        eof_o,
   output logic [15:0] frame_cnt_o
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_t;

   localparam logic [15:0] LP_FRAME_LEN = 16'(FRAME_LEN);

   state_t      r_state,      w_stateNext;
   logic [1:0]  r_sr,         w_srNext;
   logic [15:0] r_bitCnt,     w_bitCntNext;
   logic        r_tailSecond, w_tailSecondNext;
   logic        r_valid,      w_validNext;
   logic [1:0]  r_sym,        w_symNext;
   logic        r_sof,        w_sofNext;
   logic        r_eof,        w_eofNext;
   logic [15:0] r_frameCnt,   w_frameCntNext;

   logic        w_slotFree;
   logic        w_ready;
   logic        w_accept;
   logic        w_bit;
   logic [1:0]  w_code;
   logic [15:0] w_bitCntInc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_sr         <= 2'b00;
         r_bitCnt     <= 16'd0;
         r_tailSecond <= 1'b0;
         r_valid      <= 1'b0;
         r_sym        <= 2'b00;
         r_sof        <= 1'b0;
         r_eof        <= 1'b0;
         r_frameCnt   <= 16'd0;
      end else begin
         r_state      <= w_stateNext;
         r_sr         <= w_srNext;
         r_bitCnt     <= w_bitCntNext;
         r_tailSecond <= w_tailSecondNext;
         r_valid      <= w_validNext;
         r_sym        <= w_symNext;
         r_sof        <= w_sofNext;
         r_eof        <= w_eofNext;
         r_frameCnt   <= w_frameCntNext;
      end
   end

   // Ready is gated by rst so it stays low for the whole time reset is asserted.
   always_comb begin
      w_slotFree       = !r_valid || ready_i;
      w_ready          = rst && ((r_state == S_IDLE) || (r_state == S_DATA)) && w_slotFree;
      w_accept         = enable_encoder_i && w_ready;
      w_bit            = (r_state == S_TAIL) ? 1'b0 : encoder_i;
      w_code           = {w_bit ^ r_sr[1] ^ r_sr[0], w_bit ^ r_sr[0]};
      w_bitCntInc      = r_bitCnt + 16'd1;

      w_stateNext      = r_state;
      w_srNext         = r_sr;
      w_bitCntNext     = r_bitCnt;
      w_tailSecondNext = r_tailSecond;
      w_validNext      = r_valid;
      w_symNext        = r_sym;
      w_sofNext        = r_sof;
      w_eofNext        = r_eof;
      w_frameCntNext   = r_frameCnt;

      if (w_slotFree) begin
         w_validNext = 1'b0;
         w_sofNext   = 1'b0;
         w_eofNext   = 1'b0;
      end

      case (r_state)
         S_IDLE, S_DATA: begin
            if (w_accept) begin
               w_validNext  = 1'b1;
               w_symNext    = w_code;
               w_sofNext    = (r_state == S_IDLE);
               w_eofNext    = 1'b0;
               w_srNext     = {w_bit, r_sr[1]};
               w_bitCntNext = w_bitCntInc;
               w_stateNext  = (w_bitCntInc == LP_FRAME_LEN) ? S_TAIL : S_DATA;
            end
         end
         S_TAIL: begin
            // Two zero-input symbols flush the encoder; the second one closes the frame.
            if (w_slotFree) begin
               w_validNext      = 1'b1;
               w_symNext        = w_code;
               w_sofNext        = 1'b0;
               w_eofNext        = 1'b0;
               w_srNext         = {1'b0, r_sr[1]};
               w_tailSecondNext = !r_tailSecond;
               if (r_tailSecond) begin
                  w_eofNext      = 1'b1;
                  w_frameCntNext = r_frameCnt + 16'd1;
                  w_srNext       = 2'b00;
                  w_bitCntNext   = 16'd0;
                  w_stateNext    = S_IDLE;
               end
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   assign encoder_ready_o = w_ready;
   assign encoder_o       = r_sym;
   assign valid_o         = r_valid;
   assign sof_o           = r_sof;
   assign eof_o           = r_eof;
   assign frame_cnt_o     = r_frameCnt;

endmodule

// File: tb/tb_conv_enc_framer.sv
// Self-checking bench for conv_enc_framer: three instances (FRAME_LEN 1, 4, 256) driven with
// random bits and random backpressure, compared against a frame-level convolution model.
module tb_conv_enc_framer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn [3];
   logic        en   [3];
   logic        din  [3];
   logic        rdy  [3];
   logic        erdy [3];
   logic [1:0]  sym  [3];
   logic        vld  [3];
   logic        sof  [3];
   logic        eof  [3];
   logic [15:0] fcnt [3];

   logic [15:0] expFrames [3];
   logic [3:0]  gotQ [$];
   logic [3:0]  expQ [$];
   int          nChecks = 0;
   int          nPass   = 0;

   // Entries are packed as {symbol[1:0], sof, eof}.
   logic [3:0] knownExp   [6] = '{4'b1110, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b1101};
   logic [3:0] impulseExp [3] = '{4'b1110, 4'b1000, 4'b1101};

   conv_enc_framer #(.FRAME_LEN(1)) u_dutFl1 (
      .clk(clk), .rst(rstn[0]), .encoder_i(din[0]), .enable_encoder_i(en[0]),
      .encoder_ready_o(erdy[0]), .encoder_o(sym[0]), .valid_o(vld[0]), .ready_i(rdy[0]),
      .sof_o(sof[0]), .eof_o(eof[0]), .frame_cnt_o(fcnt[0]));

   conv_enc_framer #(.FRAME_LEN(4)) u_dutFl4 (
      .clk(clk), .rst(rstn[1]), .encoder_i(din[1]), .enable_encoder_i(en[1]),
      .encoder_ready_o(erdy[1]), .encoder_o(sym[1]), .valid_o(vld[1]), .ready_i(rdy[1]),
      .sof_o(sof[1]), .eof_o(eof[1]), .frame_cnt_o(fcnt[1]));

   conv_enc_framer #(.FRAME_LEN(256)) u_dutFl256 (
      .clk(clk), .rst(rstn[2]), .encoder_i(din[2]), .enable_encoder_i(en[2]),
      .encoder_ready_o(erdy[2]), .encoder_o(sym[2]), .valid_o(vld[2]), .ready_i(rdy[2]),
      .sof_o(sof[2]), .eof_o(eof[2]), .frame_cnt_o(fcnt[2]));

   // Bit k of frame f, with zeros outside the frame (before its start and in the tail).
   function automatic bit frame_bit(input bit bq[$], input int f, input int flen, input int k);
      if (k < 0 || k >= flen) return 1'b0;
      return bq[f * flen + k];
   endfunction

   // Each symbol is the mod-2 convolution of the frame bits with taps 111 and 101.
   function automatic void build_expected(input bit bq[$], input int flen);
      bit b0, b1, b2;
      expQ.delete();
      for (int f = 0; f < bq.size() / flen; f++) begin
         for (int n = 0; n < flen + 2; n++) begin
            b0 = frame_bit(bq, f, flen, n);
            b1 = frame_bit(bq, f, flen, n - 1);
            b2 = frame_bit(bq, f, flen, n - 2);
            expQ.push_back({b0 ^ b1 ^ b2, b0 ^ b2, n == 0, n == flen + 1});
         end
      end
   endfunction

   task automatic step(input int d, input logic e, input logic b, input logic r, output logic acc);
      @(negedge clk);
      en[d]  = e;
      din[d] = b;
      rdy[d] = r;
      #1;
      acc = en[d] && erdy[d];
      if (vld[d] && rdy[d]) gotQ.push_back({sym[d], sof[d], eof[d]});
   endtask

   task automatic run_stream(input int d, input bit bq[$], input int readyPct, input int nSyms,
                             output int cycles);
      int   idx = 0;
      logic a;
      bit   have, b;
      cycles = 0;
      while (gotQ.size() < nSyms && cycles < nSyms * 20 + 50) begin
         have = (idx < bq.size());
         b    = 1'b0;
         if (have) b = bq[idx];
         step(d, have, b, $urandom_range(99) < readyPct, a);
         if (a) idx++;
         cycles++;
      end
      en[d] = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      for (int d = 0; d < 3; d++) begin
         nChecks++;
         if ({vld[d], sym[d], sof[d], eof[d], erdy[d], fcnt[d]} !== 22'd0)
            $display("[TB] FAIL reset_async[%0d] got %b expected all zero", d,
                     {vld[d], sym[d], sof[d], eof[d], erdy[d], fcnt[d]});
         else nPass++;
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         nChecks++;
         if ({vld[d], erdy[d], fcnt[d]} !== 18'd0)
            $display("[TB] FAIL reset_held[%0d] got %b expected all zero", d, {vld[d], erdy[d], fcnt[d]});
         else nPass++;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         rstn[d]      = 1'b1;
         expFrames[d] = 16'd0;
      end
   endtask

   task automatic test_impulse();
      bit bq[$];
      int cyc;
      bq = '{1'b1};
      gotQ.delete();
      run_stream(0, bq, 100, 3, cyc);
      nChecks++;
      if (gotQ.size() !== 3) $display("[TB] FAIL impulse_count got %0d expected 3", gotQ.size());
      else nPass++;
      for (int i = 0; i < gotQ.size() && i < 3; i++) begin
         nChecks++;
         if (gotQ[i] !== impulseExp[i])
            $display("[TB] FAIL impulse_sym[%0d] got %b expected %b", i, gotQ[i], impulseExp[i]);
         else nPass++;
      end
      expFrames[0] = expFrames[0] + 16'd1;
      nChecks++;
      if (fcnt[0] !== expFrames[0]) $display("[TB] FAIL impulse_frames got %0d expected %0d", fcnt[0], expFrames[0]);
      else nPass++;
   endtask

   task automatic test_fl1_stream();
      bit bq[$];
      int cyc;
      for (int i = 0; i < 100; i++) bq.push_back(1'($urandom_range(1)));
      build_expected(bq, 1);
      gotQ.delete();
      run_stream(0, bq, 75, expQ.size(), cyc);
      nChecks++;
      if (gotQ.size() !== expQ.size()) $display("[TB] FAIL fl1_count got %0d expected %0d", gotQ.size(), expQ.size());
      else nPass++;
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         nChecks++;
         if (gotQ[i] !== expQ[i]) $display("[TB] FAIL fl1_sym[%0d] got %b expected %b", i, gotQ[i], expQ[i]);
         else nPass++;
      end
      expFrames[0] = expFrames[0] + 16'd100;
      nChecks++;
      if (fcnt[0] !== expFrames[0]) $display("[TB] FAIL fl1_frames got %0d expected %0d", fcnt[0], expFrames[0]);
      else nPass++;
   endtask

   // Preloads the frame counter near its top instead of running 65534 real frames.
   task automatic test_frame_wrap();
      bit   bq[$];
      int   cyc;
      logic a;
      step(0, 1'b0, 1'b0, 1'b1, a);
      step(0, 1'b0, 1'b0, 1'b1, a);
      force u_dutFl1.r_frameCnt = 16'hFFFE;
      repeat (2) @(posedge clk);
      @(negedge clk);
      release u_dutFl1.r_frameCnt;
      bq = '{1'($urandom_range(1)), 1'($urandom_range(1))};
      gotQ.delete();
      run_stream(0, bq, 100, 6, cyc);
      nChecks++;
      if (fcnt[0] !== 16'h0000) $display("[TB] FAIL wrap_to_zero got %h expected 0000", fcnt[0]);
      else nPass++;
      bq = '{1'b1};
      gotQ.delete();
      run_stream(0, bq, 100, 3, cyc);
      nChecks++;
      if (fcnt[0] !== 16'h0001) $display("[TB] FAIL wrap_after got %h expected 0001", fcnt[0]);
      else nPass++;
   endtask

   task automatic test_known_frame();
      logic [3:0] kb = 4'b1101;
      logic       a;
      int         cyc = 0;
      gotQ.delete();
      for (int i = 0; i < 4; i++) begin
         step(1, 1'b1, kb[i], 1'b1, a);
         nChecks++;
         if (a !== 1'b1) $display("[TB] FAIL known_accept[%0d] got %b expected 1", i, a);
         else nPass++;
      end
      for (int i = 0; i < 2; i++) begin
         step(1, 1'b1, 1'b1, 1'b1, a);
         nChecks++;
         if ({a, erdy[1]} !== 2'b00) $display("[TB] FAIL known_tail_ready[%0d] got %b expected 00", i, {a, erdy[1]});
         else nPass++;
      end
      while (gotQ.size() < 6 && cyc < 20) begin
         step(1, 1'b0, 1'b0, 1'b1, a);
         cyc++;
      end
      nChecks++;
      if (gotQ.size() !== 6) $display("[TB] FAIL known_count got %0d expected 6", gotQ.size());
      else nPass++;
      for (int i = 0; i < gotQ.size() && i < 6; i++) begin
         nChecks++;
         if (gotQ[i] !== knownExp[i]) $display("[TB] FAIL known_sym[%0d] got %b expected %b", i, gotQ[i], knownExp[i]);
         else nPass++;
      end
      expFrames[1] = expFrames[1] + 16'd1;
      nChecks++;
      if (fcnt[1] !== expFrames[1]) $display("[TB] FAIL known_frames got %0d expected %0d", fcnt[1], expFrames[1]);
      else nPass++;
   endtask

   task automatic test_backpressure();
      logic [3:0] kb = 4'b1101;
      logic       a;
      int         idx = 0;
      int         cyc = 0;
      bit         have;
      gotQ.delete();
      for (int i = 0; i < 2; i++) begin
         step(1, 1'b1, kb[idx], 1'b1, a);
         if (a) idx++;
      end
      // The second symbol (10) is parked in the output register during the stall.
      for (int i = 0; i < 5; i++) begin
         step(1, 1'b1, kb[idx], 1'b0, a);
         nChecks++;
         if ({a, erdy[1], vld[1], sym[1], sof[1], eof[1]} !== 7'b0011000)
            $display("[TB] FAIL stall_hold[%0d] got %b expected 0011000", i,
                     {a, erdy[1], vld[1], sym[1], sof[1], eof[1]});
         else nPass++;
      end
      while (gotQ.size() < 6 && cyc < 30) begin
         have = (idx < 4);
         step(1, have, have ? kb[idx[1:0]] : 1'b0, 1'b1, a);
         if (a) idx++;
         cyc++;
      end
      en[1] = 1'b0;
      nChecks++;
      if (gotQ.size() !== 6) $display("[TB] FAIL stall_count got %0d expected 6", gotQ.size());
      else nPass++;
      for (int i = 0; i < gotQ.size() && i < 6; i++) begin
         nChecks++;
         if (gotQ[i] !== knownExp[i]) $display("[TB] FAIL stall_sym[%0d] got %b expected %b", i, gotQ[i], knownExp[i]);
         else nPass++;
      end
      expFrames[1] = expFrames[1] + 16'd1;
      nChecks++;
      if (fcnt[1] !== expFrames[1]) $display("[TB] FAIL stall_frames got %0d expected %0d", fcnt[1], expFrames[1]);
      else nPass++;
   endtask

   task automatic test_back_to_back();
      bit bq[$];
      int cyc;
      int nSof = 0;
      int nEof = 0;
      for (int i = 0; i < 12; i++) bq.push_back(1'($urandom_range(1)));
      build_expected(bq, 4);
      gotQ.delete();
      run_stream(1, bq, 100, 18, cyc);
      nChecks++;
      if (gotQ.size() !== 18) $display("[TB] FAIL b2b_count got %0d expected 18", gotQ.size());
      else nPass++;
      nChecks++;
      if (cyc !== 19) $display("[TB] FAIL b2b_cycles got %0d expected 19", cyc);
      else nPass++;
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         nSof += int'(gotQ[i][1]);
         nEof += int'(gotQ[i][0]);
         nChecks++;
         if (gotQ[i] !== expQ[i]) $display("[TB] FAIL b2b_sym[%0d] got %b expected %b", i, gotQ[i], expQ[i]);
         else nPass++;
      end
      nChecks++;
      if (nSof !== 3 || nEof !== 3) $display("[TB] FAIL b2b_markers got sof=%0d eof=%0d expected 3/3", nSof, nEof);
      else nPass++;
      expFrames[1] = expFrames[1] + 16'd3;
      nChecks++;
      if (fcnt[1] !== expFrames[1]) $display("[TB] FAIL b2b_frames got %0d expected %0d", fcnt[1], expFrames[1]);
      else nPass++;
   endtask

   task automatic test_reset_mid_frame();
      bit   bq[$];
      logic a;
      int   cyc;
      step(1, 1'b1, 1'b1, 1'b1, a);
      step(1, 1'b1, 1'b0, 1'b1, a);
      #2;
      rstn[1] = 1'b0;
      #1;
      nChecks++;
      if ({vld[1], sym[1], sof[1], eof[1], erdy[1], fcnt[1]} !== 22'd0)
         $display("[TB] FAIL midreset_async got %b expected all zero", {vld[1], sym[1], sof[1], eof[1], erdy[1], fcnt[1]});
      else nPass++;
      @(posedge clk);
      #2;
      rstn[1]      = 1'b1;
      expFrames[1] = 16'd0;
      gotQ.delete();
      step(1, 1'b1, 1'b1, 1'b1, a);
      nChecks++;
      if (a !== 1'b1) $display("[TB] FAIL midreset_first_accept got %b expected 1", a);
      else nPass++;
      bq = '{1'b0, 1'b1, 1'b0};
      run_stream(1, bq, 100, 6, cyc);
      bq = '{1'b1, 1'b0, 1'b1, 1'b0};
      build_expected(bq, 4);
      nChecks++;
      if (gotQ.size() !== 6) $display("[TB] FAIL midreset_count got %0d expected 6", gotQ.size());
      else nPass++;
      for (int i = 0; i < gotQ.size() && i < 6; i++) begin
         nChecks++;
         if (gotQ[i] !== expQ[i]) $display("[TB] FAIL midreset_sym[%0d] got %b expected %b", i, gotQ[i], expQ[i]);
         else nPass++;
      end
      nChecks++;
      if (fcnt[1] !== 16'd1) $display("[TB] FAIL midreset_frames got %0d expected 1", fcnt[1]);
      else nPass++;
   endtask

   task automatic test_scoreboard();
      bit bq[$];
      int cyc;
      for (int i = 0; i < 512; i++) bq.push_back(1'($urandom_range(1)));
      build_expected(bq, 256);
      gotQ.delete();
      run_stream(2, bq, 60, 516, cyc);
      nChecks++;
      if (gotQ.size() !== 516) $display("[TB] FAIL sb_count got %0d expected 516", gotQ.size());
      else nPass++;
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
         nChecks++;
         if (gotQ[i] !== expQ[i]) $display("[TB] FAIL sb_sym[%0d] got %b expected %b", i, gotQ[i], expQ[i]);
         else nPass++;
      end
      expFrames[2] = expFrames[2] + 16'd2;
      nChecks++;
      if (fcnt[2] !== expFrames[2]) $display("[TB] FAIL sb_frames got %0d expected %0d", fcnt[2], expFrames[2]);
      else nPass++;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rstn[d] = 1'b0;
         en[d]   = 1'b0;
         din[d]  = 1'b0;
         rdy[d]  = 1'b1;
      end
      test_reset();
      test_impulse();
      test_fl1_stream();
      test_frame_wrap();
      test_known_frame();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_scoreboard();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
